// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the three handshake groups that meet at the
// memory arbiter. These are the fetch port (imem*), the load/store port
// (dmem*) and the shared memory port (mem*). The arb_grant trace output
// is bundled here as well.
// The slave modport is the arbiter's view of the bundle. The master modport
// is the view of whatever surrounds it (processor plus memory).
interface mem_arbiter_if #(
  parameter int p_nbits = 32
);
  // Instruction-fetch port
  logic               imemreq_val;
  logic               imemreq_rdy;
  logic [p_nbits-1:0] imemreq_addr;
  logic               imemresp_val;
  logic [p_nbits-1:0] imemresp_data;

  // Load/store port
  logic               dmemreq_val;
  logic               dmemreq_rdy;
  logic               dmemreq_type;
  logic [p_nbits-1:0] dmemreq_addr;
  logic [p_nbits-1:0] dmemreq_wdata;
  logic               dmemresp_val;
  logic [p_nbits-1:0] dmemresp_data;

  // Shared memory port
  logic               memreq_val;
  logic               memreq_rdy;
  logic               memreq_type;
  logic [p_nbits-1:0] memreq_addr;
  logic [p_nbits-1:0] memreq_wdata;
  logic               memresp_val;
  logic [p_nbits-1:0] memresp_data;

  // Trace: one-hot {dmem, imem} owner of the outstanding transaction
  logic [1:0]         arb_grant;

  modport slave (
    input  imemreq_val, imemreq_addr,
    input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    input  memreq_rdy, memresp_val, memresp_data,
    output imemreq_rdy, imemresp_val, imemresp_data,
    output dmemreq_rdy, dmemresp_val, dmemresp_data,
    output memreq_val, memreq_type, memreq_addr, memreq_wdata,
    output arb_grant
  );

  modport master (
    output imemreq_val, imemreq_addr,
    output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    output memreq_rdy, memresp_val, memresp_data,
    input  imemreq_rdy, imemresp_val, imemresp_data,
    input  dmemreq_rdy, dmemresp_val, dmemresp_data,
    input  memreq_val, memreq_type, memreq_addr, memreq_wdata,
    input  arb_grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the instruction-fetch
// port and the load/store port. Only one transaction is outstanding at a time.
// The request and response paths are both combinational. The only state is
// the IDLE/WAIT FSM, the grant register and, optionally, the round-robin
// pointer.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN for a round-robin grant, where
// the pointer favours the port that lost the previous handshake. With it
// undefined, the grant is fixed priority and dmem always beats imem.
// rst is asynchronous and active-low. Its effect on the outputs is
// immediate, because every combinational output is qualified with rst.
module mem_arbiter #(
  parameter int p_nbits = 32
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    PORT_IMEM = 1'b0,
    PORT_DMEM = 1'b1
  } port_e;

  state_e     state_q;
  logic [1:0] grant_q;    // {dmem, imem} owner of the outstanding transaction
  port_e      winner;     // combinational choice while IDLE

  logic in_idle;
  logic in_wait;
  logic any_val;
  logic handshake;
  logic resp_fire;

  // Reset forces the FSM into IDLE asynchronously. The qualification with
  // rst here also silences the request outputs while reset is held.
  assign in_idle   = rst && (state_q == ST_IDLE);
  assign in_wait   = rst && (state_q == ST_WAIT);
  assign any_val   = bus.imemreq_val | bus.dmemreq_val;
  assign handshake = in_idle & any_val & bus.memreq_rdy;
  assign resp_fire = in_wait & bus.memresp_val;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  port_e ptr_q;           // favoured port when both request together

  // Round-robin pick: a lone requester wins. Under contention the pointer decides.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    winner = PORT_IMEM;
    if (bus.dmemreq_val && (!bus.imemreq_val || (ptr_q == PORT_DMEM))) begin
      winner = PORT_DMEM;
    end
  end
`else
  // Fixed priority pick: any dmem request beats imem.
  always_comb begin
    winner = PORT_IMEM;
    if (bus.dmemreq_val) begin
      winner = PORT_DMEM;
    end
  end
`endif

  // Request mux: forward the winner's fields to memory while IDLE, zero otherwise.
  always_comb begin
    bus.memreq_val   = 1'b0;
    bus.memreq_type  = 1'b0;
    bus.memreq_addr  = '0;
    bus.memreq_wdata = '0;
    if (in_idle && any_val) begin
      bus.memreq_val = 1'b1;
      if (winner == PORT_DMEM) begin
        bus.memreq_type  = bus.dmemreq_type;
        bus.memreq_addr  = bus.dmemreq_addr;
        bus.memreq_wdata = bus.dmemreq_wdata;
      end else begin
        // Fetches are always reads that carry no store data.
        bus.memreq_addr  = bus.imemreq_addr;
      end
    end
  end

  // Ready fan-back: only the winning, valid port sees memory's ready.
  always_comb begin
    bus.imemreq_rdy = in_idle & bus.imemreq_val & (winner == PORT_IMEM) & bus.memreq_rdy;
    bus.dmemreq_rdy = in_idle & bus.dmemreq_val & (winner == PORT_DMEM) & bus.memreq_rdy;
  end

  // Response steering: route the memory pulse to the granted port in the same
  // cycle. A pulse that arrives in IDLE is dropped.
  always_comb begin
    bus.imemresp_val  = resp_fire & grant_q[0];
    bus.dmemresp_val  = resp_fire & grant_q[1];
    bus.imemresp_data = bus.imemresp_val ? bus.memresp_data : '0;
    bus.dmemresp_data = bus.dmemresp_val ? bus.memresp_data : '0;
  end

  assign bus.arb_grant = grant_q;

  // FSM: latch the winner on handshake. Release it when the response returns.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: this block holds only state, so it uses non-blocking assignments
    // and every register sees a consistent pre-edge snapshot of its inputs.
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= PORT_DMEM;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            state_q <= ST_WAIT;
            grant_q <= (winner == PORT_DMEM) ? 2'b10 : 2'b01;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // The port that lost this round is favoured next time.
            ptr_q   <= (winner == PORT_DMEM) ? PORT_IMEM : PORT_DMEM;
`endif
          end
        end
        ST_WAIT: begin
          if (resp_fire) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. It works with both builds.
// Expected grant orders are selected with the same MEM_ARB_ROUND_ROBIN_EN
// macro. Inputs change just after a falling edge. Outputs are sampled 1 ns
// later, which is well clear of the rising edge.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter_if #(.p_nbits(32)) bus ();

  mem_arbiter #(.p_nbits(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.imemreq_val   = 1'b0;
    bus.imemreq_addr  = '0;
    bus.dmemreq_val   = 1'b0;
    bus.dmemreq_type  = 1'b0;
    bus.dmemreq_addr  = '0;
    bus.dmemreq_wdata = '0;
    bus.memreq_rdy    = 1'b0;
    bus.memresp_val   = 1'b0;
    bus.memresp_data  = '0;
  endtask

  // Reset with every input active: all outputs must stay silent.
  task automatic test_reset();
    rst = 1'b0;
    bus.imemreq_val   = 1'b1;
    bus.imemreq_addr  = 32'h0000_0123;
    bus.dmemreq_val   = 1'b1;
    bus.dmemreq_type  = 1'b1;
    bus.dmemreq_addr  = 32'h0000_0456;
    bus.dmemreq_wdata = 32'h0000_0789;
    bus.memreq_rdy    = 1'b1;
    bus.memresp_val   = 1'b1;
    bus.memresp_data  = 32'hffff_ffff;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy, bus.imemresp_val, bus.dmemresp_val} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy, bus.imemresp_val, bus.dmemresp_val});
    end
    n_checks++;
    if ({bus.memreq_type, bus.memreq_addr, bus.memreq_wdata} !== 65'd0) begin
      n_fail++;
      $display("FAIL reset_fields: type=%b addr=%h wdata=%h expected all zero",
               bus.memreq_type, bus.memreq_addr, bus.memreq_wdata);
    end
    n_checks++;
    if (bus.arb_grant !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_grant: got %b expected 00", bus.arb_grant);
    end
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
  endtask

  // Single fetch at 0x200 returning 0xdeadbeef.
  task automatic test_single_fetch();
    @(negedge clk);
    bus.imemreq_val  = 1'b1;
    bus.imemreq_addr = 32'h0000_0200;
    bus.memreq_rdy   = 1'b1;
    #1;
    n_checks++;
    if ({bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy, bus.memreq_type} !== 4'b1100) begin
      n_fail++;
      $display("FAIL fetch_req_ctrl: val/irdy/drdy/type got %b expected 1100",
               {bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy, bus.memreq_type});
    end
    n_checks++;
    if ({bus.memreq_addr, bus.memreq_wdata} !== {32'h0000_0200, 32'h0}) begin
      n_fail++;
      $display("FAIL fetch_req_fields: addr=%h wdata=%h expected 00000200/0", bus.memreq_addr, bus.memreq_wdata);
    end
    @(negedge clk);
    bus.imemreq_val  = 1'b0;
    bus.memresp_val  = 1'b1;
    bus.memresp_data = 32'hdead_beef;
    #1;
    n_checks++;
    if (bus.arb_grant !== 2'b01) begin
      n_fail++;
      $display("FAIL fetch_grant: got %b expected 01", bus.arb_grant);
    end
    n_checks++;
    if ({bus.imemresp_val, bus.dmemresp_val, bus.imemresp_data} !== {2'b10, 32'hdead_beef}) begin
      n_fail++;
      $display("FAIL fetch_resp: ival=%b dval=%b data=%h expected 1 0 deadbeef",
               bus.imemresp_val, bus.dmemresp_val, bus.imemresp_data);
    end
    @(negedge clk);
    bus.memresp_val = 1'b0;
    #1;
    n_checks++;
    if (bus.arb_grant !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_grant_clear: got %b expected 00", bus.arb_grant);
    end
  endtask

  // Store of 0x55 to 0x1000: the response pulses the dmem port only.
  task automatic test_store();
    @(negedge clk);
    bus.dmemreq_val   = 1'b1;
    bus.dmemreq_type  = 1'b1;
    bus.dmemreq_addr  = 32'h0000_1000;
    bus.dmemreq_wdata = 32'h0000_0055;
    bus.memreq_rdy    = 1'b1;
    #1;
    n_checks++;
    if ({bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy, bus.memreq_type} !== 4'b1011) begin
      n_fail++;
      $display("FAIL store_req_ctrl: val/irdy/drdy/type got %b expected 1011",
               {bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy, bus.memreq_type});
    end
    n_checks++;
    if ({bus.memreq_addr, bus.memreq_wdata} !== {32'h0000_1000, 32'h0000_0055}) begin
      n_fail++;
      $display("FAIL store_req_fields: addr=%h wdata=%h expected 00001000/00000055", bus.memreq_addr, bus.memreq_wdata);
    end
    @(negedge clk);
    bus.dmemreq_val = 1'b0;
    bus.memresp_val = 1'b1;
    #1;
    n_checks++;
    if ({bus.arb_grant, bus.imemresp_val, bus.dmemresp_val} !== 4'b1001) begin
      n_fail++;
      $display("FAIL store_resp: grant/ival/dval got %b expected 1001",
               {bus.arb_grant, bus.imemresp_val, bus.dmemresp_val});
    end
    @(negedge clk);
    bus.memresp_val = 1'b0;
    clear_inputs();
  endtask

  // Both ports request continuously, and memory answers one cycle after each accept.
  task automatic test_contention();
    logic [1:0] exp_grant [4];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_grant = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_grant = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.imemreq_val  = 1'b1;
      bus.imemreq_addr = 32'h0000_0300;
      bus.dmemreq_val  = 1'b1;
      bus.dmemreq_type = 1'b0;
      bus.dmemreq_addr = 32'h0000_0400;
      bus.memreq_rdy   = 1'b1;
      bus.memresp_val  = 1'b0;
      #1;
      n_checks++;
      if ({bus.memreq_val, bus.dmemreq_rdy, bus.imemreq_rdy} !== {1'b1, exp_grant[i]}) begin
        n_fail++;
        $display("FAIL contention_rdy[%0d]: val/drdy/irdy got %b expected %b",
                 i, {bus.memreq_val, bus.dmemreq_rdy, bus.imemreq_rdy}, {1'b1, exp_grant[i]});
      end
      n_checks++;
      if (bus.memreq_addr !== (exp_grant[i][1] ? 32'h0000_0400 : 32'h0000_0300)) begin
        n_fail++;
        $display("FAIL contention_addr[%0d]: got %h expected %h",
                 i, bus.memreq_addr, exp_grant[i][1] ? 32'h0000_0400 : 32'h0000_0300);
      end
      @(negedge clk);
      bus.memresp_val  = 1'b1;
      bus.memresp_data = 32'h0000_0a00 + i;
      #1;
      n_checks++;
      if ({bus.arb_grant, bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy} !== {exp_grant[i], 3'b000}) begin
        n_fail++;
        $display("FAIL contention_grant[%0d]: grant=%b val/irdy/drdy=%b expected %b 000",
                 i, bus.arb_grant, {bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy}, exp_grant[i]);
      end
      n_checks++;
      if ({bus.dmemresp_val, bus.imemresp_val} !== exp_grant[i]) begin
        n_fail++;
        $display("FAIL contention_resp[%0d]: dval/ival got %b expected %b",
                 i, {bus.dmemresp_val, bus.imemresp_val}, exp_grant[i]);
      end
    end
    @(negedge clk);
    bus.memresp_val = 1'b0;
  endtask

  // Memory stalls for 3 cycles with both ports valid, then accepts on the 4th cycle.
  task automatic test_backpressure();
    logic [1:0] exp_next;
    bus.imemreq_val  = 1'b1;
    bus.imemreq_addr = 32'h0000_0300;
    bus.dmemreq_val  = 1'b1;
    bus.dmemreq_addr = 32'h0000_0400;
    bus.memreq_rdy   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy, bus.memreq_addr} !== {3'b100, 32'h0000_0400}) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: val/irdy/drdy=%b addr=%h expected 100 00000400",
                 c, {bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy}, bus.memreq_addr);
      end
      @(negedge clk);
    end
    bus.memreq_rdy = 1'b1;
    #1;
    n_checks++;
    if ({bus.dmemreq_rdy, bus.imemreq_rdy, bus.memreq_addr} !== {2'b10, 32'h0000_0400}) begin
      n_fail++;
      $display("FAIL bp_accept: drdy/irdy=%b addr=%h expected 10 00000400",
               {bus.dmemreq_rdy, bus.imemreq_rdy}, bus.memreq_addr);
    end
    @(negedge clk);
    bus.memresp_val = 1'b1;
    #1;
    n_checks++;
    if (bus.arb_grant !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_grant: got %b expected 10", bus.arb_grant);
    end
    @(negedge clk);
    bus.memresp_val = 1'b0;
    // The stalled cycles did not move the pointer. The single handshake
    // above moved it once, so the next round goes to the port it favours.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_next = 2'b01;
`else
    exp_next = 2'b10;
`endif
    #1;
    n_checks++;
    if ({bus.dmemreq_rdy, bus.imemreq_rdy} !== exp_next) begin
      n_fail++;
      $display("FAIL bp_next_winner: drdy/irdy got %b expected %b", {bus.dmemreq_rdy, bus.imemreq_rdy}, exp_next);
    end
    @(negedge clk);
    bus.memresp_val = 1'b1;
    @(negedge clk);
    clear_inputs();
  endtask

  // Spurious response in IDLE, then reset during WAIT, then a late response and a fresh fetch.
  task automatic test_spurious_reset();
    @(negedge clk);
    bus.memresp_val  = 1'b1;
    bus.memresp_data = 32'h1234_5678;
    #1;
    n_checks++;
    if ({bus.imemresp_val, bus.dmemresp_val, bus.memreq_val} !== 3'b000) begin
      n_fail++;
      $display("FAIL spurious_idle: ival/dval/mval got %b expected 000",
               {bus.imemresp_val, bus.dmemresp_val, bus.memreq_val});
    end
    @(negedge clk);
    bus.memresp_val  = 1'b0;
    bus.imemreq_val  = 1'b1;
    bus.imemreq_addr = 32'h0000_0220;
    bus.memreq_rdy   = 1'b1;
    #1;
    n_checks++;
    if (bus.arb_grant !== 2'b00) begin
      n_fail++;
      $display("FAIL spurious_grant: got %b expected 00", bus.arb_grant);
    end
    @(negedge clk);
    // The arbiter is now in WAIT for imem. Reset arrives together with a response.
    rst = 1'b0;
    bus.memresp_val = 1'b1;
    #1;
    n_checks++;
    if ({bus.arb_grant, bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy, bus.imemresp_val, bus.dmemresp_val} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_in_wait: grant/val/irdy/drdy/ival/dval got %b expected 0000000",
               {bus.arb_grant, bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy, bus.imemresp_val, bus.dmemresp_val});
    end
    @(negedge clk);
    rst = 1'b1;
    bus.imemreq_val = 1'b0;
    #1;
    n_checks++;
    if ({bus.imemresp_val, bus.dmemresp_val, bus.arb_grant} !== 4'b0000) begin
      n_fail++;
      $display("FAIL late_resp_dropped: ival/dval/grant got %b expected 0000",
               {bus.imemresp_val, bus.dmemresp_val, bus.arb_grant});
    end
    @(negedge clk);
    bus.memresp_val  = 1'b0;
    bus.imemreq_val  = 1'b1;
    bus.imemreq_addr = 32'h0000_0240;
    #1;
    n_checks++;
    if ({bus.memreq_val, bus.imemreq_rdy, bus.memreq_addr} !== {2'b11, 32'h0000_0240}) begin
      n_fail++;
      $display("FAIL post_reset_req: val/irdy=%b addr=%h expected 11 00000240",
               {bus.memreq_val, bus.imemreq_rdy}, bus.memreq_addr);
    end
    @(negedge clk);
    bus.imemreq_val  = 1'b0;
    bus.memresp_val  = 1'b1;
    bus.memresp_data = 32'hcafe_f00d;
    #1;
    n_checks++;
    if ({bus.arb_grant, bus.imemresp_val, bus.imemresp_data} !== {3'b011, 32'hcafe_f00d}) begin
      n_fail++;
      $display("FAIL post_reset_resp: grant=%b ival=%b data=%h expected 01 1 cafef00d",
               bus.arb_grant, bus.imemresp_val, bus.imemresp_data);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_backpressure();
    test_spurious_reset();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-way arbiter sharing one single-ported memory between the processor's instruction-fetch port (imem) and its load/store port (dmem). It sits between the processor and memory. Both sides use latency-insensitive val/rdy requests and single-cycle response pulses. At most one transaction is outstanding at a time. Grant policy is round-robin or fixed-priority, selected at compile time.

## Interface
- p_nbits, 32, address and data width.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; asserted when 0.
- imemreq_val  input  1  fetch request valid.
- imemreq_rdy  output  1  fetch request accepted this cycle.
- imemreq_addr  input  p_nbits  fetch address.
- imemresp_val  output  1  fetch response valid (one-cycle pulse).
- imemresp_data  output  p_nbits  fetch response data.
- dmemreq_val  input  1  load/store request valid.
- dmemreq_rdy  output  1  load/store request accepted this cycle.
- dmemreq_type  input  1  0 = read, 1 = write.
- dmemreq_addr  input  p_nbits  load/store address.
- dmemreq_wdata  input  p_nbits  store data.
- dmemresp_val  output  1  load/store response valid (one-cycle pulse).
- dmemresp_data  output  p_nbits  load data; don't-care for writes.
- memreq_val / memreq_rdy  output / input  1  memory request handshake.
- memreq_type  output  1  0 = read, 1 = write.
- memreq_addr, memreq_wdata  output  p_nbits  memory request fields.
- memresp_val  input  1  memory response valid.
- memresp_data  input  p_nbits  memory response data.
- arb_grant  output  2  trace: one-hot owner of the outstanding transaction ({dmem, imem}); 00 when idle.

## Operation
- State machine has two states: IDLE and WAIT.
- **IDLE**
  - memreq_val = imemreq_val | dmemreq_val.
  - Winner is chosen combinationally by the policy. memreq_* fields mux from the winner.
  - When imem wins: memreq_type = 0 and memreq_wdata = 0.
  - Winner's req_rdy = memreq_rdy. Loser's req_rdy = 0.
- **IDLE → WAIT** on memreq_val & memreq_rdy.
  - Winner is latched into the grant register (arb_grant).
  - The priority pointer updates.
- **WAIT**
  - memreq_val = 0 and both req_rdy = 0.
  - On memresp_val: the granted port's resp_val = 1 and resp_data = memresp_data, both combinational (same cycle).
  - The other port's resp_val stays 0.
  - Next state is IDLE and the grant clears.
- memresp_val seen in IDLE is spurious and dropped; no output asserts.
- Requesters hold val and fields stable until accepted. The pointer changes only on handshake, so the winner and memreq_* stay stable while memreq_val & !memreq_rdy.
- Response data is never buffered. Requesters must accept response pulses unconditionally.

## Timing
- Reset (rst = 0, takes effect immediately):
  - State = IDLE, arb_grant = 00, priority pointer = dmem.
  - memreq_val = 0, both req_rdy = 0, both resp_val = 0.
  - memreq_addr, memreq_wdata and memreq_type = 0 while reset is held.
- Request path is combinational, 0 cycles from requester to memory.
- Response path is combinational, 0 cycles from memory to requester.
- Minimum spacing is 2 cycles per transaction: accept in cycle N, response no earlier than N+1, next accept no earlier than N+2.
- The arbiter never issues a new request in the same cycle a response returns.
- Simultaneous requests in IDLE: the policy decides. The losing request stays pending with rdy = 0.
- Reset asserted in WAIT abandons the transaction. A memresp_val arriving after reset deasserts is dropped as spurious.
- A request held across many cycles of memreq_rdy = 0 does not advance the pointer.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined:
  - One-bit pointer names the favored port; pointer starts at dmem.
  - After each handshake, the pointer moves to the port that did not win.
- Undefined:
  - Fixed priority: dmem always beats imem; pointer logic absent.
  - Sustained dmem traffic may starve imem.
- arb_grant, handshakes and timing are identical in both builds.

## Test plan
- Single fetch: imemreq_val = 1, addr = 0x200, memreq_rdy = 1 → memreq_addr = 0x200, type = 0; arb_grant = 01. Next cycle memresp_val = 1, data = 0xdeadbeef → imemresp_val = 1, data = 0xdeadbeef; dmemresp_val = 0.
- Store: dmem write, addr = 0x1000, wdata = 0x55 → memreq_type = 1, memreq_wdata = 0x55. Response pulses dmemresp_val only.
- Contention, both valid every cycle, memory responds after 1 cycle:
  - With MEM_ARB_ROUND_ROBIN_EN, grants alternate dmem, imem, dmem, imem.
  - Without it, 4 grants all go to dmem and imemreq_rdy stays 0.
- Backpressure: memreq_rdy = 0 for 3 cycles with both valid → memreq_addr constant and both rdy = 0. Accepted on cycle 4; pointer unchanged before acceptance.
- Spurious/reset: memresp_val pulse in IDLE → no resp_val. Assert rst in WAIT → all outputs 0 at once. After release, a late memresp_val is dropped and a new imem request is granted normally.
